aes_inv_round: RTL
==================

AES_INV_ROUND -- requirements
Module: aes_inv_round

Interface
- REQ-001 The block SHALL have no parameters.
- REQ-002 clk  input  1  single clock; all state updates on the rising edge.
- REQ-003 rst  input  1  reset, synchronous, active-high.
- REQ-004 in_valid  input  1  upstream offers a state/key pair.
- REQ-005 in_ready  output  1  block can accept a new pair.
- REQ-006 in_state  input  128  [0:127]; byte i = in_state[8i+:8]; column c = bytes 4c..4c+3; row r = i mod 4.
- REQ-007 round_key  input  128  same byte ordering as in_state.
- REQ-008 mix_en  input  1  1 = apply InvMixColumns; 0 = skip it (final decryption round).
- REQ-009 out_valid  output  1  out_state holds a completed result.
- REQ-010 out_ready  input  1  downstream accepts the result.
- REQ-011 out_state  output  128  [0:127] result, same byte ordering.

Function
- REQ-012 The block SHALL compute out = M(InvShiftRows(in_state) XOR round_key), where M = InvMixColumns if mix_en else identity.
- REQ-013 InvShiftRows SHALL map output byte (r,c) from input byte (r,(c-r) mod 4).
- REQ-014 InvMixColumns SHALL map column a0..a3 to b_r = 0E*a_r ^ 0B*a_(r+1) ^ 0D*a_(r+2) ^ 09*a_(r+3), indices mod 4, over GF(2^8) with modulus 0x11B.
- REQ-015 in_state, round_key and mix_en SHALL be captured on the acceptance edge (in_valid && in_ready); later input changes SHALL NOT affect that result.
- REQ-016 FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1, out_valid=0; on acceptance go to BUSY with col=0.
  - BUSY: 2-bit col counter; each cycle computes and writes output column col; col 3 written -> DONE.
  - DONE: out_valid=1; on out_valid && out_ready go to IDLE.
- REQ-017 Latency: out_valid SHALL rise after the 4th rising edge following the acceptance edge, with exactly one column computed per BUSY cycle.
- REQ-018 in_ready SHALL be 1 only in IDLE, so there is no overlap; in_valid outside IDLE SHALL be ignored.
- REQ-019 In DONE, out_state and out_valid SHALL stay stable until the handshake; out_ready without out_valid SHALL have no effect.
- REQ-020 After the output handshake, in_ready SHALL be 1 in the next cycle; the minimum spacing between acceptances is 6 cycles.
- REQ-021 out_state SHALL reflect only completed columns: partially updated contents SHALL NOT be observable while out_valid=1.

Reset
- REQ-022 When rst=1 at a rising edge, the FSM SHALL go to IDLE, col=0, out_valid=0, in_ready=1 and out_state=128'h0.
- REQ-023 Reset in BUSY or DONE SHALL discard the transaction, and no out_valid SHALL follow for it.
- REQ-024 rst SHALL take priority over any simultaneous handshake.

Verification
- REQ-025 in_state=00 01 02..0f, key=0, mix_en=0 -> out_state=000d0a07 04010e0b 0805020f 0c090603, with out_valid 4 edges after acceptance.
- REQ-026 in_state={8e4da1bc}x4, key=0, mix_en=1 -> out_state={db135345}x4; also {9fdc589d}x4 -> {f20a225c}x4.
- REQ-027 in_state=0, key=00112233..eeff, mix_en=0 -> out_state equals key; with mix_en=1 and key={01010101}x4 -> {01010101}x4.
- REQ-028 Hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new data -> out_state stable, in_ready=0, no second acceptance; release -> IDLE the next cycle.
- REQ-029 Assert rst at BUSY col=2 -> next cycle IDLE, out_state=0, out_valid=0; a subsequent transaction produces the correct result.
- REQ-030 Back-to-back random transactions with random out_ready stalls -> all results match the reference model, in order, with no loss or duplication.

Source files
------------

// File: rtl/aes_inv_round.sv
// aes_inv_round: one AES decryption round, computed one column per cycle.
//
//   out = M(InvShiftRows(in_state) ^ round_key), M = InvMixColumns when mix_en
//   is set, otherwise identity (final decryption round).
//
// Byte i of every 128-bit bus lives at [8i+:8]; column c is bytes 4c..4c+3 and
// row r = i mod 4.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   upstream offers in_state/round_key/mix_en
//   in_ready   block can accept (IDLE only)
//   in_state   128-bit cipher state
//   round_key  128-bit round key
//   mix_en     1 = apply InvMixColumns
//   out_valid  out_state holds a completed result (DONE only)
//   out_ready  downstream accepts the result
//   out_state  128-bit result
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; the sender holds its data stable while valid is high and ready is low.
//
// Flow: IDLE -> (accept) BUSY -> 4 cycles, one column each -> DONE -> (out
// handshake) IDLE. InvShiftRows and AddRoundKey are applied on the acceptance
// edge; each BUSY cycle then replaces one column in place with its mixed
// value. Since column c of the result only depends on column c of that
// intermediate, one 128-bit register serves as both source and result.
module aes_inv_round (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] round_key,
    input  logic         mix_en,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [1:0]   col;
    logic         mix_q;
    logic [127:0] data_q;
    logic [31:0]  col_in;
    logic [31:0]  col_out;
    logic         accept;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiplies by 09, 0B, 0D, 0E built from the x2/x4/x8 doublings.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [7:0] x1 [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [31:0] res;
        for (int r = 0; r < 4; r++) begin
            x1[r] = a[8*r +: 8];
            x2[r] = xtime(x1[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
            m9[r] = x8[r] ^ x1[r];
            mb[r] = x8[r] ^ x2[r] ^ x1[r];
            md[r] = x8[r] ^ x4[r] ^ x1[r];
            me[r] = x8[r] ^ x4[r] ^ x2[r];
        end
        for (int r = 0; r < 4; r++) begin
            res[8*r +: 8] = me[r] ^ mb[(r + 1) % 4] ^ md[(r + 2) % 4] ^ m9[(r + 3) % 4];
        end
        inv_mix_col = res;
    endfunction

    // Output byte (r,c) takes input byte (r,(c-r) mod 4).
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] res;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[8*(4*c + r) +: 8] = s[8*(4*((c - r + 4) % 4) + r) +: 8];
            end
        end
        inv_shift_rows = res;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_state = data_q;
    assign accept    = in_valid && in_ready;

    assign col_in  = data_q[{col, 5'b0} +: 32];
    assign col_out = mix_q ? inv_mix_col(col_in) : col_in;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = BUSY;
            BUSY:    if (col == 2'd3) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            col    <= 2'd0;
            mix_q  <= 1'b0;
            data_q <= 128'h0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_q <= inv_shift_rows(in_state) ^ round_key;
                        mix_q  <= mix_en;
                        col    <= 2'd0;
                    end
                end
                BUSY: begin
                    data_q[{col, 5'b0} +: 32] <= col_out;
                    col                       <= col + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
